// File: rtl/time_dmr_pkg.sv
// Shared types for the time-DMR retry front end.
// ID width and the feedback bundle seen by the retry buffer.
package time_dmr_pkg;

  localparam int unsigned DefIdSize = 4;

  typedef logic [DefIdSize-1:0] id_t;

  typedef struct packed {
    id_t  id;
    logic needed;
  } fb_t;

endpackage

// File: rtl/dmr_retry_table.sv
// Payload copies indexed by ID plus the occupied-bit vector.
// Asynchronous read port serves replays of the retry ID.
module dmr_retry_table #(
  parameter type         DataType = logic [7:0],
  parameter int unsigned IDSize   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 set_i,
  input  logic [IDSize-1:0]    set_idx_i,
  input  DataType              set_data_i,
  input  logic                 clr_i,
  input  logic [IDSize-1:0]    clr_idx_i,
  input  logic [IDSize-1:0]    rd_idx_i,
  output DataType              rd_data_o,
  output logic [2**IDSize-1:0] occ_o
);

  localparam int unsigned Depth = 2**IDSize;

  DataType           r_mem [Depth];
  logic [Depth-1:0]  r_occ;

  always_ff @(posedge clk_i) begin
    if (set_i) r_mem[set_idx_i] <= set_data_i;
  end

  // set and clear never target the same entry: set needs it free, clear needs it occupied
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_occ <= '0;
    end else begin
      if (set_i) r_occ[set_idx_i] <= 1'b1;
      if (clr_i) r_occ[clr_idx_i] <= 1'b0;
    end
  end

  assign rd_data_o = r_mem[rd_idx_i];
  assign occ_o     = r_occ;

endmodule

// File: rtl/dmr_retry_buffer.sv
// Retry buffer ahead of time_DMR_start: stores each issued item by ID
// and replays it with its original ID when the DMR checker reports a fault.
module dmr_retry_buffer
  import time_dmr_pkg::*;
#(
  parameter type         DataType = logic [7:0],
  parameter int unsigned IDSize   = DefIdSize
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic [IDSize-1:0] retry_id_i,
  input  logic              retry_needed_i,
  input  logic              retry_valid_i,
  output logic              retry_ready_o,
  output logic [IDSize:0]   pending_o,
  output logic              protocol_error_o
);

  localparam logic [IDSize:0]   PendOne = 1;
  localparam logic [IDSize-1:0] IdOne   = 1;

  logic [IDSize-1:0]    r_next_id;
  logic                 r_retry_full;
  logic [IDSize-1:0]    r_retry_id;
  logic [IDSize:0]      r_pend;
  logic                 r_perr;
  logic                 r_valid;
  DataType              r_data;
  logic [IDSize-1:0]    r_id;

  fb_t                  w_fb;
  logic [IDSize-1:0]    w_rid;
  logic [2**IDSize-1:0] w_occ;
  DataType              w_rd_data;
  logic                 w_load_en;
  logic                 w_fb_hs;
  logic                 w_fb_occ;
  logic                 w_fb_err;
  logic                 w_fb_replay;
  logic                 w_fb_free;
  logic                 w_replay_out;
  logic                 w_can_alloc;
  logic                 w_alloc;

  assign w_fb  = '{id: id_t'(retry_id_i), needed: retry_needed_i};
  assign w_rid = IDSize'(w_fb.id);

  assign w_load_en    = !r_valid || ready_i;
  assign w_fb_hs      = retry_valid_i && !r_retry_full;
  assign w_fb_occ     = w_occ[w_rid];
  assign w_fb_err     = w_fb_hs && !w_fb_occ;
  assign w_fb_replay  = w_fb_hs && w_fb_occ && w_fb.needed && enable_i;
  assign w_fb_free    = w_fb_hs && w_fb_occ && !(w_fb.needed && enable_i);
  assign w_replay_out = w_load_en && r_retry_full;
  assign w_can_alloc  = w_load_en && !r_retry_full && !w_occ[r_next_id];
  assign w_alloc      = w_can_alloc && valid_i;

  dmr_retry_table #(
    .DataType (DataType),
    .IDSize   (IDSize)
  ) u_table (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (w_alloc),
    .set_idx_i  (r_next_id),
    .set_data_i (data_i),
    .clr_i      (w_fb_free),
    .clr_idx_i  (w_rid),
    .rd_idx_i   (r_retry_id),
    .rd_data_o  (w_rd_data),
    .occ_o      (w_occ)
  );

  // a replay leaving and a new retry arriving are exclusive via the full bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_retry_full <= 1'b0;
      r_retry_id   <= '0;
    end else if (w_replay_out) begin
      r_retry_full <= 1'b0;
    end else if (w_fb_replay) begin
      r_retry_full <= 1'b1;
      r_retry_id   <= w_rid;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_next_id <= '0;
      r_pend    <= '0;
      r_perr    <= 1'b0;
    end else begin
      r_perr <= w_fb_err;
      if (w_alloc) r_next_id <= r_next_id + IdOne;
      unique case ({w_alloc, w_fb_free})
        2'b10:   r_pend <= r_pend + PendOne;
        2'b01:   r_pend <= r_pend - PendOne;
        default: r_pend <= r_pend;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
    end else if (w_load_en) begin
      if (w_replay_out) begin
        r_valid <= 1'b1;
        r_data  <= w_rd_data;
        r_id    <= r_retry_id;
      end else if (w_alloc) begin
        r_valid <= 1'b1;
        r_data  <= data_i;
        r_id    <= r_next_id;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ready_o          = w_can_alloc;
  assign retry_ready_o    = !r_retry_full;
  assign data_o           = r_data;
  assign id_o             = r_id;
  assign valid_o          = r_valid;
  assign pending_o        = r_pend;
  assign protocol_error_o = r_perr;

endmodule
